hilo_md_unit: RTL and testbench
===============================

Name: hilo_md_unit

Overview:
Parametrised successor to the HI/LO register pair. It combines the HI/LO registers with an iterative multiply/divide engine that takes one bit per cycle, and keeps the direct HI/LO write ports used for MTHI/MTLO. The block sits beside the EX stage. The pipeline stalls on busy, and results retire into HI/LO without a separate writeback path.

Parameters:
DATA_W, 32, width of the operands, HI and LO
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request a multiply/divide; accepted only when busy=0
op  in  3  operation code, sampled with start
src_a  in  DATA_W  multiplicand or dividend, sampled with start
src_b  in  DATA_W  multiplier or divisor, sampled with start
cancel  in  1  pipeline flush; aborts the operation in flight
we_hi  in  1  direct HI write (MTHI)
hi_data_in  in  DATA_W  data for the direct HI write
we_lo  in  1  direct LO write (MTLO)
lo_data_in  in  DATA_W  data for the direct LO write
busy  out  1  engine is not IDLE
done  out  1  one-cycle pulse after the result has been written
div_zero  out  1  one-cycle pulse, coincident with done, when a divide had src_b=0
hi_data_out  out  DATA_W  registered HI value
lo_data_out  out  DATA_W  registered LO value

Behaviour:
- Reset (async, rst=0): state=IDLE; HI=0, LO=0; busy=0, done=0, div_zero=0. Reset mid-operation discards the operation in flight.
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU. Codes 4-7 are legal only with HILO_ACC_EN.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: on start, latch operand magnitudes (signed ops) or raw operands (unsigned ops), latch result sign, clear the counter, go to CALC. start during any other state is ignored.
- CALC: one shift-add (multiply) or restoring-subtract (divide) step per edge. After DATA_W edges, go to FIX.
- FIX: apply sign correction.
  - Multiply: negate the 2*DATA_W product if the operand signs differ.
  - Divide: quotient is negative if the signs differ; remainder takes the sign of the dividend.
  - Write the result on this edge. Multiply: {HI,LO}=product. Divide: LO=quotient, HI=remainder. Go to DONE.
- DONE: done=1 for exactly this cycle, then return to IDLE.
- busy = (state != IDLE).
- Latency: start sampled at edge 0; HI/LO updated at edge DATA_W+1; done high in the cycle after edge DATA_W+1; start accepted again at edge DATA_W+2.
- Divide by zero: HI and LO are unchanged; div_zero pulses together with done.
- Signed MIN/-1 result: LO=MIN, HI=0. No trap.
- Direct writes are applied on any edge, in any state. On the FIX edge, the engine write wins over we_hi/we_lo.
- cancel: takes effect in any non-IDLE state and returns to IDLE on the next edge. No HI/LO write, no done. cancel together with start in IDLE: start is ignored.
- Simultaneous we_hi and we_lo: both registers are written.

Optional Feature:
HILO_ACC_EN
- Defined: ops 4-7 are enabled. At the FIX edge, {HI,LO} is updated to {HI,LO} ± the signed or unsigned product, using HI/LO as they stand at that edge (modulo 2^(2*DATA_W)).
- Undefined: ops 4-7 are treated as no-ops. They are accepted, busy=0 on the next cycle, no done pulse, and HI/LO are unchanged.

Decomposition:
- Shared define file/package: DATA_W default, op code constants, FSM state encoding, RstEnable=1'b0 polarity constant.
- One sub-module, hilo_md_engine: holds the iterative datapath (operand latches, counter, partial product and remainder shift registers). It is started and cleared by the top-level FSM.
- The top level holds the FSM, sign fixups, the HI/LO registers and the write arbitration.

Test Plan:
- Reset: rst=0 mid-CALC -> HI=LO=0, busy=0 immediately, no done.
- MULT: src_a=0xFFFFFFFE (-2), src_b=3 -> done at cycle 34 after start; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV signs: src_a=-7, src_b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU src_a=100, src_b=7 -> LO=14, HI=2. DIVU src_b=0 with HI=0x11, LO=0x22 -> HI/LO unchanged, div_zero=1 with done.
- Write arbitration: we_hi=1, hi_data_in=0x400 during CALC -> HI=0x400 at the next edge. we_lo=1 on the FIX edge -> LO holds the engine result.
- Flow control: start pulsed while busy -> ignored, single done. cancel at CALC cycle 10 -> IDLE next edge, no HI/LO change, no done.
- HILO_ACC_EN: HI=0, LO=0xFFFFFFFF, MADDU 1×1 -> HI=1, LO=0. MSUB 1×1 from HI=LO=0 -> HI=LO=0xFFFFFFFF.

Source files
------------

// File: rtl/hilo_md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: widths, op codes,
// FSM encoding, reset polarity and the op decoder.
package hilo_md_pkg;

    localparam int   DATA_W_DEF = 32;
    localparam int   CNT_W_DEF  = 6;
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
        logic is_acc;
        logic is_sub;
    } op_ctrl_t;

    // Even codes are the signed flavours; codes 4-7 accumulate into HI/LO.
    function automatic op_ctrl_t decode_op(input logic [2:0] op);
        op_ctrl_t d;
        d.is_div    = (op[2:1] == 2'b01);
        d.is_signed = ~op[0];
        d.is_acc    = op[2];
        d.is_sub    = op[2] & op[1];
        return d;
    endfunction

endpackage

// File: rtl/hilo_md_engine.sv
// Iterative one-bit-per-cycle datapath: shift-add multiply and restoring
// divide on unsigned magnitudes. Loaded and stepped by the hilo_md_unit FSM.
module hilo_md_engine
    import hilo_md_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              last,
    output logic [DATA_W-1:0] prod_hi,
    output logic [DATA_W-1:0] prod_lo
);

    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] acc_hi_q;
    logic [DATA_W-1:0] acc_lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              div_q;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;
    logic              div_ge;
    logic [DATA_W-1:0] nxt_hi;
    logic [DATA_W-1:0] nxt_lo;

    // Multiply: {acc_hi, acc_lo} holds partial product and remaining multiplier bits.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_hi    = acc_hi_q;
        nxt_lo    = acc_lo_q;
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_q) begin
            nxt_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
            nxt_lo = {acc_lo_q[DATA_W-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[DATA_W:1];
            nxt_lo = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst == RST_ENABLE) begin
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
        end else if (load) begin
            opb_q    <= b_in;
            acc_hi_q <= '0;
            acc_lo_q <= a_in;
            cnt_q    <= '0;
            div_q    <= is_div;
        end else if (step) begin
            acc_hi_q <= nxt_hi;
            acc_lo_q <= nxt_lo;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    assign last    = (cnt_q == CNT_W'(DATA_W - 1));
    assign prod_hi = acc_hi_q;
    assign prod_lo = acc_lo_q;

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO register pair with iterative multiply/divide and MTHI/MTLO writes.
// Define HILO_ACC_EN to enable MADD/MADDU/MSUB/MSUBU (ops 4-7).
module hilo_md_unit
    import hilo_md_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    input  logic              we_hi,
    input  logic [DATA_W-1:0] hi_data_in,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] lo_data_in,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_data_out,
    output logic [DATA_W-1:0] lo_data_out
);

    localparam int PW = 2 * DATA_W;

    state_e            state, next_state;
    op_ctrl_t          dec;
    logic              op_ok;
    logic              start_go;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    logic              div_q, neg_res_q, neg_rem_q, dz_q;
    logic [DATA_W-1:0] hi_q, lo_q;

    logic              eng_last;
    logic [DATA_W-1:0] eng_hi, eng_lo;
    logic [PW-1:0]     prod_fix;
    logic [DATA_W-1:0] quo_fix, rem_fix;
    logic [DATA_W-1:0] res_hi, res_lo;
    logic              eng_we;

    assign dec = decode_op(op);

`ifdef HILO_ACC_EN
    assign op_ok = 1'b1;
`else
    // Accumulate ops are accepted but do nothing when the feature is absent.
    assign op_ok = ~(dec.is_acc | dec.is_sub);
`endif

    assign start_go = (state == ST_IDLE) && start && !cancel && op_ok;

    assign a_neg = dec.is_signed & src_a[DATA_W-1];
    assign b_neg = dec.is_signed & src_b[DATA_W-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    hilo_md_engine #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_engine (
        .clk     (clk),
        .rst     (rst),
        .load    (start_go),
        .step    ((state == ST_CALC) && !cancel),
        .is_div  (dec.is_div),
        .a_in    (a_mag),
        .b_in    (b_mag),
        .last    (eng_last),
        .prod_hi (eng_hi),
        .prod_lo (eng_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (start_go) next_state = ST_CALC;
            ST_CALC: begin
                if (cancel)        next_state = ST_IDLE;
                else if (eng_last) next_state = ST_FIX;
            end
            ST_FIX:  next_state = cancel ? ST_IDLE : ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        div_zero = (state == ST_DONE) && dz_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (start_go) begin
            div_q     <= dec.is_div;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= dec.is_div && (src_b == '0);
        end
    end

`ifdef HILO_ACC_EN
    logic acc_q, sub_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            acc_q <= 1'b0;
            sub_q <= 1'b0;
        end else if (start_go) begin
            acc_q <= dec.is_acc;
            sub_q <= dec.is_sub;
        end
    end
`endif

    // Magnitude negation also covers MIN / -1: quotient wraps back to MIN, remainder 0.
    assign prod_fix = neg_res_q ? -{eng_hi, eng_lo} : {eng_hi, eng_lo};
    assign quo_fix  = neg_res_q ? -eng_lo : eng_lo;
    assign rem_fix  = neg_rem_q ? -eng_hi : eng_hi;

    always_comb begin
        res_hi = prod_fix[PW-1:DATA_W];
        res_lo = prod_fix[DATA_W-1:0];
        if (div_q) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
`ifdef HILO_ACC_EN
        else if (acc_q) begin
            {res_hi, res_lo} = sub_q ? ({hi_q, lo_q} - prod_fix) : ({hi_q, lo_q} + prod_fix);
        end
`endif
    end

    // Divide by zero leaves HI/LO alone; the engine write beats MTHI/MTLO on the FIX edge.
    assign eng_we = (state == ST_FIX) && !cancel && !dz_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (eng_we)     hi_q <= res_hi;
            else if (we_hi) hi_q <= hi_data_in;
            if (eng_we)     lo_q <= res_lo;
            else if (we_lo) lo_q <= lo_data_in;
        end
    end

    assign hi_data_out = hi_q;
    assign lo_data_out = lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Scoreboard bench for hilo_md_unit: directed vectors push expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_hilo_md_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         cancel = 1'b0;
    logic         we_hi = 1'b0;
    logic [W-1:0] hi_data_in = '0;
    logic         we_lo = 1'b0;
    logic [W-1:0] lo_data_in = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi_data_out, lo_data_out;

    hilo_md_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .we_hi       (we_hi),
        .hi_data_in  (hi_data_in),
        .we_lo       (we_lo),
        .lo_data_in  (lo_data_in),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi_data_out (hi_data_out),
        .lo_data_out (lo_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           s;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   dones = 0;
    int   pushes = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (div_zero === 1'b1 && done !== 1'b1) check("div_zero_without_done", 1, 0);
            if (done === 1'b1) begin
                dones++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_hi", hi_data_out, e.hi);
                    check("result_lo", lo_data_out, e.lo);
                    check("div_zero", div_zero, e.dz);
                    check("latency", cyc - e.s, W + 1);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edz, output int s);
        wait_idle();
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        s = cyc + 1;
        if (push) begin
            sb.push_back('{ehi, elo, edz, s});
            pushes++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        we_hi = 1'b1;
        we_lo = 1'b1;
        hi_data_in = h;
        lo_data_in = l;
        @(negedge clk);
        we_hi = 1'b0;
        we_lo = 1'b0;
        check("mthi_mtlo_hi", hi_data_out, h);
        check("mthi_mtlo_lo", lo_data_out, l);
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        check("reset_hi", hi_data_out, 0);
        check("reset_lo", lo_data_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b1;
        @(negedge clk);

        set_hilo(32'h11, 32'h22);
        issue(3'd3, 32'd100, 32'd0, 1, 32'h11, 32'h22, 1'b1, s);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, s);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, s);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, s);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE, 1, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, s);
        issue(3'd3, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, s);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 1'b0, s);
        issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, s);

        // MTHI mid-CALC lands at once; MTLO on the FIX edge loses to the engine.
        issue(3'd1, 32'd5, 32'd6, 1, 32'h0, 32'h1E, 1'b0, s);
        wait_cyc(s + 4);
        we_hi = 1'b1;
        hi_data_in = 32'h400;
        @(negedge clk);
        we_hi = 1'b0;
        check("mthi_during_calc", hi_data_out, 32'h400);
        wait_cyc(s + 32);
        we_lo = 1'b1;
        lo_data_in = 32'hDEAD;
        @(negedge clk);
        we_lo = 1'b0;
        check("fix_beats_mtlo", lo_data_out, 32'h1E);

        // A second start while busy must be ignored.
        issue(3'd1, 32'd2, 32'd3, 1, 32'h0, 32'h6, 1'b0, s);
        wait_cyc(s + 3);
        src_a = 32'd9;
        src_b = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("start_while_busy_lo", lo_data_out, 32'h6);

        issue(3'd3, 32'd100, 32'd7, 0, '0, '0, 1'b0, s);
        wait_cyc(s + 9);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        repeat (40) @(negedge clk);
        check("cancel_hi", hi_data_out, 32'h0);
        check("cancel_lo", lo_data_out, 32'h6);

        op = 3'd1;
        start = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        check("cancel_with_start_busy", busy, 0);

`ifdef HILO_ACC_EN
        set_hilo(32'h0, 32'hFFFF_FFFF);
        issue(3'd5, 32'd1, 32'd1, 1, 32'h1, 32'h0, 1'b0, s);
        wait_idle();
        set_hilo(32'h0, 32'h0);
        issue(3'd6, 32'd1, 32'd1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, s);
        wait_idle();
`else
        set_hilo(32'h55, 32'h66);
        op = 3'd5;
        src_a = 32'd3;
        src_b = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("acc_noop_busy", busy, 0);
        repeat (40) @(negedge clk);
        check("acc_noop_hi", hi_data_out, 32'h55);
        check("acc_noop_lo", lo_data_out, 32'h66);
`endif

        // Asynchronous reset in the middle of CALC.
        issue(3'd0, 32'd3, 32'd4, 0, '0, '0, 1'b0, s);
        wait_cyc(s + 5);
        #2 rst = 1'b0;
        #1;
        check("midop_reset_hi", hi_data_out, 0);
        check("midop_reset_lo", lo_data_out, 0);
        check("midop_reset_busy", busy, 0);
        check("midop_reset_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        check("pending_results", sb.size(), 0);
        check("done_count", dones, pushes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
